fns_result_checker: RTL and testbench

//  Downstream consumer of the function-semantics DUT: takes each operand pair (in1,in2) with the five DUT results
//  (out1..out5), recomputes golden values per the SystemVerilog function-argument/return sizing rules, and records

---
 rtl/fns_check_pkg.sv | 38 +++
 rtl/fns_err_fifo.sv | 61 ++++++
 rtl/fns_result_checker.sv | 131 +++++++++++++
 tb/tb_fns_result_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fns_check_pkg.sv
// Shared types and the golden model for checking the function-semantics DUT.
// fns_golden() is the single source of the sizing rules used by the checker.
package fns_check_pkg;

    localparam int REC_W = 37;

    typedef struct packed {
        logic [15:0] idx;
        logic [7:0]  in1;
        logic [7:0]  in2;
        logic [4:0]  mask;
    } err_rec_t;

    // Element [k-1] holds the expected value of outk.
    typedef logic [4:0][7:0] golden_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } chk_state_e;

    function automatic golden_t fns_golden(input logic [7:0] in1, input logic [7:0] in2);
        logic       a0;
        logic       b0;
        logic [3:0] t;
        golden_t    g;
        a0   = in1[0];
        b0   = in2[0];
        t    = in1[3:0] & in2[3:0];
        g[0] = {8{a0 ^ b0}};
        g[1] = {7'b0, a0 & b0};
        g[2] = {{4{t[3]}}, t};
        g[3] = {7'b0, a0 & b0};
        g[4] = {7'b0, $signed(in1[3:0]) < $signed(in2[3:0])};
        return g;
    endfunction

endpackage

// File: rtl/fns_err_fifo.sv
// Synchronous FIFO for mismatch records. When empty, the head output keeps
// showing the most recently popped record.
module fns_err_fifo
    import fns_check_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  err_rec_t                 i_data,
    input  logic                     i_pop,
    output err_rec_t                 o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    err_rec_t        r_mem [DEPTH];
    err_rec_t        r_last;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_cnt;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_cnt == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && (r_cnt != '0);
    // A pop in the same edge frees the slot being written, so a full FIFO may still accept.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_last   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    assign o_valid = (r_cnt != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : r_last;
    assign o_count = r_cnt;

endmodule

// File: rtl/fns_result_checker.sv
// Checks DUT results against the golden model: S1 captures a vector, the result
// stage compares it, updates counters and queues a record for any mismatch.
module fns_result_checker
    import fns_check_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in1,
    input  logic [7:0]        in2,
    input  logic [7:0]        out1,
    input  logic [7:0]        out2,
    input  logic [7:0]        out3,
    input  logic [7:0]        out4,
    input  logic [7:0]        out5,
    output logic              err_valid,
    input  logic              err_ready,
    output logic [REC_W-1:0]  err_data,
    output logic [CNT_W-1:0]  check_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              halted,
    output chk_state_e        dbg_state
);

    localparam int FCW = $clog2(DEPTH) + 1;
    localparam int OCW = FCW + 1;

    chk_state_e       r_state;
    logic             r_halted;
    logic             r_s1_valid;
    logic [7:0]       r_s1_in1;
    logic [7:0]       r_s1_in2;
    golden_t          r_s1_out;
    logic [CNT_W-1:0] r_check_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [15:0]      r_idx;

    logic             w_accept;
    golden_t          w_exp;
    logic [4:0]       w_mask;
    logic             w_mismatch;
    err_rec_t         w_rec;
    err_rec_t         w_head;
    logic             w_fifo_valid;
    logic [FCW-1:0]   w_fifo_cnt;
    logic [OCW-1:0]   w_occ;

    // Every vector in S1 may still produce a record, so it holds a FIFO slot.
    assign w_occ    = OCW'(w_fifo_cnt) + OCW'(r_s1_valid);
    assign in_ready = !rst && !r_halted && (w_occ < OCW'(DEPTH));
    assign w_accept = in_valid && in_ready;

    assign w_exp = fns_golden(r_s1_in1, r_s1_in2);

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < 5; k++) begin
            w_mask[k] = (r_s1_out[k] != w_exp[k]);
        end
    end

    assign w_mismatch = r_s1_valid && (w_mask != '0);
    assign w_rec      = '{idx: r_idx, in1: r_s1_in1, in2: r_s1_in2, mask: w_mask};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_halted    <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_in1    <= '0;
            r_s1_in2    <= '0;
            r_s1_out    <= '0;
            r_check_cnt <= '0;
            r_err_cnt   <= '0;
            r_idx       <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_in1 <= in1;
                r_s1_in2 <= in2;
                r_s1_out <= {out5, out4, out3, out2, out1};
            end
            if (r_s1_valid) begin
                if (r_check_cnt != '1) r_check_cnt <= r_check_cnt + 1'b1;
                if (w_mismatch && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
                r_idx <= r_idx + 16'd1;
            end
            case (r_state)
                ST_RUN: begin
                    if ((STOP_ON_ERR != 0) && w_mismatch) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    fns_err_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_mismatch),
        .i_data  (w_rec),
        .i_pop   (err_ready),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_cnt)
    );

    assign err_valid = w_fifo_valid;
    assign err_data  = w_head;
    assign check_cnt = r_check_cnt;
    assign err_cnt   = r_err_cnt;
    assign halted    = r_halted;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fns_result_checker.sv
// Bench for fns_result_checker: directed steps plus a randomized run scored
// against an arithmetic reference model and an expected-record queue.
module tb_fns_result_checker;
    import fns_check_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, err_valid, err_ready, halted;
    logic [7:0]        in1, in2, out1, out2, out3, out4, out5;
    logic [REC_W-1:0]  err_data;
    logic [15:0]       check_cnt, err_cnt;
    chk_state_e        dbg_state;

    logic              h_in_valid, h_in_ready, h_err_valid, h_err_ready, h_halted;
    logic [7:0]        h_in1, h_in2;
    logic [4:0][7:0]   h_out;
    logic [REC_W-1:0]  h_err_data;
    logic [3:0]        h_check_cnt, h_err_cnt;
    chk_state_e        h_dbg_state;

    fns_result_checker #(.DEPTH(4), .CNT_W(16), .STOP_ON_ERR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
        .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
        .check_cnt(check_cnt), .err_cnt(err_cnt), .halted(halted), .dbg_state(dbg_state)
    );

    fns_result_checker #(.DEPTH(4), .CNT_W(4), .STOP_ON_ERR(1)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in1(h_in1), .in2(h_in2), .out1(h_out[0]), .out2(h_out[1]), .out3(h_out[2]),
        .out4(h_out[3]), .out5(h_out[4]),
        .err_valid(h_err_valid), .err_ready(h_err_ready), .err_data(h_err_data),
        .check_cnt(h_check_cnt), .err_cnt(h_err_cnt), .halted(h_halted), .dbg_state(h_dbg_state)
    );

    logic [REC_W-1:0] exp_q[$];
    logic [15:0]      m_idx, m_chk, m_err;
    int               n_vec = 0, n_cmp = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from plain integer arithmetic on the operand values.
    function automatic logic [4:0][7:0] model_exp(input int a, input int b);
        int a0, b0, t, sa, sb;
        logic [4:0][7:0] e;
        a0   = a % 2;
        b0   = b % 2;
        t    = (a % 16) & (b % 16);
        sa   = (a % 16 >= 8) ? (a % 16) - 16 : a % 16;
        sb   = (b % 16 >= 8) ? (b % 16) - 16 : b % 16;
        e[0] = (a0 != b0) ? 8'hFF : 8'h00;
        e[1] = 8'(a0 * b0);
        e[2] = 8'((t >= 8) ? t + 240 : t);
        e[3] = 8'(a0 * b0);
        e[4] = (sa < sb) ? 8'd1 : 8'd0;
        return e;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_chk = 0; m_err = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic [4:0][7:0] o);
        logic [4:0][7:0] e;
        logic [4:0]      mask;
        e = model_exp(a, b);
        for (int k = 0; k < 5; k++) mask[k] = (o[k] != e[k]);
        n_vec++;
        if (m_chk != 16'hFFFF) m_chk++;
        if (mask != 0) begin
            if (m_err != 16'hFFFF) m_err++;
            exp_q.push_back({m_idx, a, b, mask});
        end
        m_idx++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of the main instance: drive, score any pop, update the model, advance.
    task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0][7:0] o, input logic rdy, output logic acc);
        in_valid = v; in1 = a; in2 = b;
        out1 = o[0]; out2 = o[1]; out3 = o[2]; out4 = o[3]; out5 = o[4];
        err_ready = rdy;
        acc = v && in_ready;
        if (err_valid && rdy) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 64'(err_valid), 64'd0);
            else chk("pop_data", 64'(err_data), 64'(exp_q.pop_front()));
        end
        if (acc) model_accept(a, b, o);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0][7:0] z, good, bad3, o4, bad5, ro;
        logic [7:0]      ra, rb;
        logic            acc;
        int              nacc, nxt;

        z    = '0;
        good = {8'h00, 8'h01, 8'hF9, 8'h01, 8'h00};
        bad3 = {8'h00, 8'h01, 8'h09, 8'h01, 8'h00};
        o4   = {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        bad5 = {5{8'hAA}};
        in_valid = 0; in1 = 0; in2 = 0; out1 = 0; out2 = 0; out3 = 0; out4 = 0; out5 = 0;
        err_ready = 0;
        h_in_valid = 0; h_in1 = 0; h_in2 = 0; h_out = '0; h_err_ready = 0;
        model_reset();

        // Reset state
        rst = 1'b1;
        step(); step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_err_valid", 64'(err_valid), 64'd0);
        chk("rst_err_data", 64'(err_data), 64'd0);
        chk("rst_check_cnt", 64'(check_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_h_in_ready", 64'(h_in_ready), 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_err_valid", 64'(err_valid), 64'd0);

        // Clean vector
        cyc(1, 8'h0F, 8'h09, good, 0, acc);
        chk("t2_accept", 64'(acc), 64'd1);
        cyc(0, 0, 0, z, 0, acc);
        chk("t2_err_valid_a", 64'(err_valid), 64'd0);
        cyc(0, 0, 0, z, 0, acc);
        chk("t2_check_cnt", 64'(check_cnt), 64'd1);
        chk("t2_err_cnt", 64'(err_cnt), 64'd0);
        chk("t2_err_valid_b", 64'(err_valid), 64'd0);

        // Fresh start so the next record carries idx 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        step();

        // Wrong out3: record appears two edges after acceptance
        cyc(1, 8'h0F, 8'h09, bad3, 0, acc);
        chk("t3_accept", 64'(acc), 64'd1);
        chk("t3_lat_e0", 64'(err_valid), 64'd0);
        cyc(0, 0, 0, z, 0, acc);
        chk("t3_lat_e1", 64'(err_valid), 64'd1);
        chk("t3_err_data", 64'(err_data), 64'({16'd0, 8'h0F, 8'h09, 5'b00100}));
        chk("t3_err_cnt", 64'(err_cnt), 64'd1);
        cyc(0, 0, 0, z, 1, acc);
        chk("t3_drained", 64'(err_valid), 64'd0);

        // Signed 4-bit compare (-8 < 1) reported wrong on out5
        cyc(1, 8'h08, 8'h01, o4, 0, acc);
        cyc(0, 0, 0, z, 0, acc);
        chk("t4_err_data", 64'(err_data), 64'({16'd1, 8'h08, 8'h01, 5'b10000}));
        cyc(0, 0, 0, z, 1, acc);
        chk("t4_drained", 64'(err_valid), 64'd0);

        // Back-pressure: only DEPTH vectors in flight or queued
        nacc = 0; nxt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(nxt < 6, 8'h10 + 8'(nxt), 8'h01, bad5, 0, acc);
            if (acc) begin nacc++; nxt++; end
        end
        chk("t5_accepted", 64'(nacc), 64'd4);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        chk("t5_err_cnt", 64'(err_cnt), 64'd6);
        cyc(0, 0, 0, z, 1, acc);
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(nxt < 6, 8'h10 + 8'(nxt), 8'h01, bad5, 0, acc);
            if (acc) begin nacc++; nxt++; end
        end
        chk("t5_one_more", 64'(nacc), 64'd1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, z, 1, acc);
        chk("t5_left", 64'(exp_q.size()), 64'd0);
        chk("t5_err_valid", 64'(err_valid), 64'd0);
        chk("t5_check_cnt", 64'(check_cnt), 64'd7);
        chk("t5_err_cnt_final", 64'(err_cnt), 64'd7);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = model_exp(ra, rb);
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(0, 3) == 0) ro[k] = 8'($urandom);
            end
            cyc($urandom_range(0, 9) < 7, ra, rb, ro, 1'($urandom_range(0, 1)), acc);
        end
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, z, 1, acc);
        chk("rand_left", 64'(exp_q.size()), 64'd0);
        chk("rand_err_valid", 64'(err_valid), 64'd0);
        chk("rand_check_cnt", 64'(check_cnt), 64'(m_chk));
        chk("rand_err_cnt", 64'(err_cnt), 64'(m_err));
        chk("rand_halted", 64'(halted), 64'd0);

        // Stop-on-error instance: two bad vectors, then a good one that must be refused
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_ready0", 64'(h_in_ready), 64'd1);
        h_in_valid = 1; h_in1 = 8'h0F; h_in2 = 8'h09; h_out = bad3;
        step();
        step();
        h_out = good;
        chk("t6_halted", 64'(h_halted), 64'd1);
        chk("t6_in_ready", 64'(h_in_ready), 64'd0);
        chk("t6_err_valid", 64'(h_err_valid), 64'd1);
        step(); step(); step();
        chk("t6_check_cnt", 64'(h_check_cnt), 64'd2);
        chk("t6_err_cnt", 64'(h_err_cnt), 64'd2);
        chk("t6_still_halted", 64'(h_halted), 64'd1);
        h_in_valid = 0;
        rst = 1'b1;
        #1;
        chk("t6_rst_err_valid", 64'(h_err_valid), 64'd0);
        chk("t6_rst_check_cnt", 64'(h_check_cnt), 64'd0);
        chk("t6_rst_err_cnt", 64'(h_err_cnt), 64'd0);
        chk("t6_rst_halted", 64'(h_halted), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Check counter saturates (4-bit counter, 20 clean vectors)
        h_in_valid = 1; h_in1 = 8'h0F; h_in2 = 8'h09; h_out = good;
        for (int i = 0; i < 20; i++) step();
        h_in_valid = 0;
        step(); step();
        chk("sat_check_cnt", 64'(h_check_cnt), 64'hF);
        chk("sat_err_cnt", 64'(h_err_cnt), 64'd0);
        chk("sat_halted", 64'(h_halted), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
